// File: rtl/dsa_simd_sequencer.sv
// Job sequencer for the SIMD bilinear-interpolation register bank.
// It fetches, loads, weighs, sums and writes back one group of N pixels at a time.
module dsa_simd_sequencer #(
    parameter int unsigned N  = 4,
    parameter int unsigned GW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [GW-1:0] num_groups_i,
    output logic          fetch_req_o,
    input  logic          fetch_done_i,
    output logic          wr_req_o,
    input  logic          wr_ack_i,
    output logic          load_pixels_en_o,
    output logic          load_coef_en_o,
    output logic          load_weights_en_o,
    output logic          load_output_en_o,
    output logic          clear_all_o,
    output logic [GW-1:0] group_idx_o,
    output logic [GW+1:0] group_base_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          aborted_o
);

    typedef enum logic [3:0] {
        StIdle,
        StClear,
        StFetch,
        StLoad,
        StWeigh,
        StSum,
        StWrite,
        StNext,
        StDone,
        StClearAbort
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] num_q, num_d;
    logic [GW-1:0] idx_q, idx_d;
    logic          aborted_q, aborted_d;
    logic          abortable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            num_q     <= '0;
            idx_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            aborted_q <= aborted_d;
        end
    end

    // Abort outranks any ack sampled in the same cycle.
    assign abortable = (state_q inside {StFetch, StLoad, StWeigh, StSum, StWrite, StNext});

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        idx_d     = idx_q;
        aborted_d = aborted_q;
        if (abortable && abort_i) begin
            state_d   = StClearAbort;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d   = StClear;
                        num_d     = num_groups_i;
                        idx_d     = '0;
                        aborted_d = 1'b0;
                    end
                end
                StClear:      state_d = (num_q == '0) ? StDone : StFetch;
                StFetch:      if (fetch_done_i) state_d = StLoad;
                StLoad:       state_d = StWeigh;
                StWeigh:      state_d = StSum;
                StSum:        state_d = StWrite;
                StWrite:      if (wr_ack_i) state_d = StNext;
                StNext: begin
                    if (idx_q == num_q - GW'(1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + GW'(1);
                        state_d = StFetch;
                    end
                end
                StDone:       state_d = StIdle;
                StClearAbort: state_d = StDone;
                default:      state_d = StIdle;
            endcase
        end
    end

    assign fetch_req_o       = (state_q == StFetch);
    assign wr_req_o          = (state_q == StWrite);
    assign load_pixels_en_o  = (state_q == StLoad);
    assign load_coef_en_o    = (state_q == StLoad);
    assign load_weights_en_o = (state_q == StWeigh);
    assign load_output_en_o  = (state_q == StSum);
    assign clear_all_o       = (state_q == StClear) || (state_q == StClearAbort);
    assign busy_o            = (state_q != StIdle);
    assign done_o            = (state_q == StDone);
    assign aborted_o         = aborted_q;
    assign group_idx_o       = idx_q;
    assign group_base_o      = (GW+2)'(idx_q) * (GW+2)'(N);

endmodule
